imem_boot_loader: RTL

//  Boot-time controller for the instruction memory: receives a program image as a byte

---
 rtl/imem_boot_loader.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//   Boot-time IMEM loader. A byte stream from the UART receiver carries a
//   little-endian 16-bit word count followed by that many little-endian 32-bit
//   words. Each word is written into IMEM in order from address 0. The CPU fetch
//   stage is stalled while a load is in progress. Outside a load, the IMEM
//   address follows the CPU program counter.
//   Build macro IMEM_BOOT_CSUM_EN: a trailing XOR checksum byte follows the last
//   word (or follows the length when the count is zero). A load completes only
//   when that byte equals the XOR of every byte received before it.
module imem_boot_loader #(
  parameter int SIZE   = 2048,
  parameter int ADDR_W = $clog2(SIZE)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_boot_req,
  input  logic              i_rx_valid,
  input  logic [7:0]        i_rx_data,
  output logic              o_rx_ready,
  input  logic [31:0]       i_pc,
  output logic              o_cpu_stall,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [31:0]       o_mem_wdata,
  output logic              o_load_done,
  output logic              o_load_err,
  output logic [ADDR_W:0]   o_words_loaded
);

  localparam logic [15:0] MaxWords = 16'(SIZE);

  typedef enum logic [2:0] {
    StIdle,
    StLen0,
    StLen1,
    StData,
    StDone,
    StErr
`ifdef IMEM_BOOT_CSUM_EN
    , StCsum
`endif
  } state_e;

  // With the checksum enabled, every successful path passes through the checksum byte first.
`ifdef IMEM_BOOT_CSUM_EN
  localparam state_e StAfterData = StCsum;
`else
  localparam state_e StAfterData = StDone;
`endif

  state_e            state_q, state_d;
  logic [7:0]        lenLo_q, lenLo_d;
  logic [15:0]       wordsTarget_q, wordsTarget_d;
  logic [1:0]        byteIdx_q, byteIdx_d;
  logic [23:0]       packBuf_q, packBuf_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
  logic [ADDR_W:0]   wordsLoaded_q, wordsLoaded_d;
  logic              err_q, err_d;
`ifdef IMEM_BOOT_CSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic        rxReady;
  logic        rxFire;
  logic [15:0] lenWord;
  logic [15:0] nextCount;
  logic        unusedPcBits;

  // The receiver is offered a byte only in states that actually consume one.
  always_comb begin
    rxReady = 1'b0;
    case (state_q)
      StLen0, StLen1, StData: rxReady = 1'b1;
`ifdef IMEM_BOOT_CSUM_EN
      StCsum:                 rxReady = 1'b1;
`endif
      default:                rxReady = 1'b0;
    endcase
  end

  assign rxFire    = i_rx_valid & rxReady;
  assign lenWord   = {i_rx_data, lenLo_q};
  assign nextCount = 16'(wordsLoaded_q) + 16'd1;

  // Next-state logic: byte framing, word packing, write strobe and error tracking.
  always_comb begin
    state_d       = state_q;
    lenLo_d       = lenLo_q;
    wordsTarget_d = wordsTarget_q;
    byteIdx_d     = byteIdx_q;
    packBuf_d     = packBuf_q;
    wdata_d       = wdata_q;
    we_d          = 1'b0;
    wrAddr_d      = wrAddr_q;
    wordsLoaded_d = wordsLoaded_q;
    err_d         = err_q;
`ifdef IMEM_BOOT_CSUM_EN
    csum_d        = csum_q;
    if (rxFire && (state_q != StCsum)) begin
      csum_d = csum_q ^ i_rx_data;
    end
`endif

    case (state_q)
      StIdle, StErr: begin
        if (i_boot_req) begin
          state_d       = StLen0;
          err_d         = 1'b0;
          wordsLoaded_d = '0;
          byteIdx_d     = '0;
`ifdef IMEM_BOOT_CSUM_EN
          csum_d        = '0;
`endif
        end
      end
      StLen0: begin
        if (rxFire) begin
          lenLo_d = i_rx_data;
          state_d = StLen1;
        end
      end
      StLen1: begin
        if (rxFire) begin
          wordsTarget_d = lenWord;
          if (lenWord == 16'd0) begin
            state_d = StAfterData;
          end else if (lenWord > MaxWords) begin
            state_d = StErr;
            err_d   = 1'b1;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (rxFire) begin
          byteIdx_d = byteIdx_q + 2'd1;
          case (byteIdx_q)
            2'd0: packBuf_d[7:0]   = i_rx_data;
            2'd1: packBuf_d[15:8]  = i_rx_data;
            2'd2: packBuf_d[23:16] = i_rx_data;
            default: begin
              wdata_d       = {i_rx_data, packBuf_q};
              we_d          = 1'b1;
              wrAddr_d      = wordsLoaded_q[ADDR_W-1:0];
              wordsLoaded_d = wordsLoaded_q + 1'b1;
              if (nextCount == wordsTarget_q) begin
                state_d = StAfterData;
              end
            end
          endcase
        end
      end
`ifdef IMEM_BOOT_CSUM_EN
      StCsum: begin
        if (rxFire) begin
          if (i_rx_data == csum_q) begin
            state_d = StDone;
          end else begin
            state_d = StErr;
            err_d   = 1'b1;
          end
        end
      end
`endif
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State register; reset abandons any load in progress without issuing further writes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= StIdle;
      lenLo_q       <= '0;
      wordsTarget_q <= '0;
      byteIdx_q     <= '0;
      packBuf_q     <= '0;
      wdata_q       <= '0;
      we_q          <= 1'b0;
      wrAddr_q      <= '0;
      wordsLoaded_q <= '0;
      err_q         <= 1'b0;
`ifdef IMEM_BOOT_CSUM_EN
      csum_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      lenLo_q       <= lenLo_d;
      wordsTarget_q <= wordsTarget_d;
      byteIdx_q     <= byteIdx_d;
      packBuf_q     <= packBuf_d;
      wdata_q       <= wdata_d;
      we_q          <= we_d;
      wrAddr_q      <= wrAddr_d;
      wordsLoaded_q <= wordsLoaded_d;
      err_q         <= err_d;
`ifdef IMEM_BOOT_CSUM_EN
      csum_q        <= csum_d;
`endif
    end
  end

  assign o_rx_ready     = rxReady;
  assign o_cpu_stall    = (state_q != StIdle) && (state_q != StErr);
  assign o_mem_we       = we_q;
  assign o_mem_wdata    = wdata_q;
  assign o_load_done    = (state_q == StDone);
  assign o_load_err     = err_q;
  assign o_words_loaded = wordsLoaded_q;

  // The loader owns the IMEM address while stalled; otherwise the PC word address drives it.
  always_comb begin
    if (o_cpu_stall) begin
      o_mem_addr = we_q ? wrAddr_q : wordsLoaded_q[ADDR_W-1:0];
    end else begin
      o_mem_addr = i_pc[ADDR_W+1:2];
    end
  end

  assign unusedPcBits = ^{i_pc[31:ADDR_W+2], i_pc[1:0]};

endmodule
